ik_dtheta: RTL and testbench

//  Downstream stage of ik_swift: consumes jacobian_matrix J and inverse M=(J*J^T+bias)^-1, plus
//  6-element pose error e, and computes the damped-least-squares joint update dtheta = J^T*(M*e).
//  One shared signed MAC runs sequentially: v=M*e, then dtheta=J^T*v. Each dtheta element is clamped
//  to +/-MAX_STEP before it goes to the joint-angle update logic.

---
 rtl/ik_dtheta.sv | 204 ++++++++++++++++++++
 tb/tb_ik_dtheta.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ik_dtheta.sv
// Damped-least-squares joint update: dtheta = clamp(J^T * (M * e)), computed on one shared
// signed MAC (36 cycles for v = M*e, then 36 cycles for d = J^T*v).
//
// state   | meaning
// IDLE    | waiting for start; outputs hold the last result
// MUL_V   | v[i] += M[i][k]*e[k], one product per cycle
// MUL_D   | d[i] += J[k][i]*v[k], clamp and write dtheta[i] at k==5
// DONE    | one-cycle done pulse, then back to IDLE
module ik_dtheta #(
  parameter int W        = 27,
  parameter int FRAC     = 16,
  parameter int GUARD    = 6,
  parameter int MAX_STEP = 1 << FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic [5:0][W-1:0]        error,
  input  logic [5:0][5:0][W-1:0]   jacobian_matrix,
  input  logic [5:0][5:0][W-1:0]   inverse,
  output logic                     busy,
  output logic                     done,
  output logic [5:0][W-1:0]        dtheta,
  output logic                     sat,
  output logic [5:0]               clamped
);

  localparam int ACC_W = 2*W - FRAC + GUARD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL_V = 2'd1;
  localparam logic [1:0] S_MUL_D = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [W-1:0] STEP_POS = W'(MAX_STEP);
  localparam logic signed [W-1:0] STEP_NEG = W'(-MAX_STEP);

  logic [1:0]               state_q, state_d;
  logic [2:0]               i_q, i_d;
  logic [2:0]               k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [5:0][W-1:0]        e_q, e_d;
  logic [5:0][5:0][W-1:0]   j_q, j_d;
  logic [5:0][5:0][W-1:0]   m_q, m_d;
  logic [5:0][W-1:0]        v_q, v_d;
  logic [5:0][W-1:0]        dtheta_q, dtheta_d;
  logic                     sat_q, sat_d;
  logic [5:0]               clamped_q, clamped_d;

  logic signed [W-1:0]      op_a;
  logic signed [W-1:0]      op_b;
  logic signed [2*W-1:0]    prod;
  logic signed [ACC_W-1:0]  sum;
  logic                     wb_ovf;
  logic signed [W-1:0]      wb;
  logic signed [W-1:0]      clamp_val;
  logic                     clamp_hit;
  logic                     last_k;
  logic                     last_i;

  // Shared MAC datapath; the MUL_D operand uses J transposed (row k, column i).
  always_comb begin
    if (state_q == S_MUL_D) begin
      op_a = $signed(j_q[k_q][i_q]);
      op_b = $signed(v_q[k_q]);
    end else begin
      op_a = $signed(m_q[i_q][k_q]);
      op_b = $signed(e_q[k_q]);
    end
    prod = op_a * op_b;
    sum  = acc_q + ACC_W'(prod >>> FRAC);

    wb_ovf = !((&sum[ACC_W-1:W-1]) || !(|sum[ACC_W-1:W-1]));
    if (wb_ovf) begin
      wb = sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      wb = sum[W-1:0];
    end

    clamp_hit = 1'b0;
    clamp_val = wb;
    if (wb > STEP_POS) begin
      clamp_val = STEP_POS;
      clamp_hit = 1'b1;
    end else if (wb < STEP_NEG) begin
      clamp_val = STEP_NEG;
      clamp_hit = 1'b1;
    end

    last_k = (k_q == 3'd5);
    last_i = (i_q == 3'd5);
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    k_d       = k_q;
    acc_d     = acc_q;
    e_d       = e_q;
    j_d       = j_q;
    m_d       = m_q;
    v_d       = v_q;
    dtheta_d  = dtheta_q;
    sat_d     = sat_q;
    clamped_d = clamped_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          e_d       = error;
          j_d       = jacobian_matrix;
          m_d       = inverse;
          acc_d     = '0;
          sat_d     = 1'b0;
          clamped_d = '0;
          i_d       = 3'd0;
          k_d       = 3'd0;
          state_d   = S_MUL_V;
        end
      end

      S_MUL_V: begin
        if (last_k) begin
          v_d[i_q] = wb;
          sat_d    = sat_q | wb_ovf;
          acc_d    = '0;
          k_d      = 3'd0;
          if (last_i) begin
            i_d     = 3'd0;
            state_d = S_MUL_D;
          end else begin
            i_d = i_q + 3'd1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 3'd1;
        end
      end

      S_MUL_D: begin
        if (last_k) begin
          dtheta_d[i_q]  = clamp_val;
          clamped_d[i_q] = clamp_hit;
          sat_d          = sat_q | wb_ovf;
          acc_d          = '0;
          k_d            = 3'd0;
          if (last_i) begin
            i_d     = 3'd0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 3'd1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 3'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      e_q       <= '0;
      j_q       <= '0;
      m_q       <= '0;
      v_q       <= '0;
      dtheta_q  <= '0;
      sat_q     <= 1'b0;
      clamped_q <= '0;
    end else if (en) begin
      state_q   <= state_d;
      i_q       <= i_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      e_q       <= e_d;
      j_q       <= j_d;
      m_q       <= m_d;
      v_q       <= v_d;
      dtheta_q  <= dtheta_d;
      sat_q     <= sat_d;
      clamped_q <= clamped_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = en && (state_q == S_DONE);
  assign dtheta  = dtheta_q;
  assign sat     = sat_q;
  assign clamped = clamped_q;

endmodule

// File: tb/tb_ik_dtheta.sv
// Directed bench for ik_dtheta: an arithmetic model of J^T*(M*e) with saturation and clamp,
// checked on every done pulse, plus literal pins and latency/reset/abort checks.
module tb_ik_dtheta;
  localparam int    W    = 27;
  localparam int    FRAC = 16;
  localparam longint ONE = 65536;
  localparam longint HI  = (64'sd1 <<< (W-1)) - 1;
  localparam longint LO  = -(64'sd1 <<< (W-1));
  localparam int    LAT  = 72;  // edges after the accept edge; done is seen in the 73rd cycle

  logic                   clk = 1'b0;
  logic                   rst, en, start;
  logic [5:0][W-1:0]      error;
  logic [5:0][5:0][W-1:0] jacobian_matrix;
  logic [5:0][5:0][W-1:0] inverse;
  logic                   busy, done, sat;
  logic [5:0][W-1:0]      dtheta;
  logic [5:0]             clamped;

  int     tests = 0;
  int     fails = 0;
  int     n_done = 0;
  int     jobs = 0;
  longint exp_d [6];
  bit     exp_sat;
  logic [5:0] exp_clamped;

  ik_dtheta dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .error(error), .jacobian_matrix(jacobian_matrix), .inverse(inverse),
    .busy(busy), .done(done), .dtheta(dtheta), .sat(sat), .clamped(clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat_w(input longint x);
    if (x > HI) begin exp_sat = 1'b1; return HI; end
    if (x < LO) begin exp_sat = 1'b1; return LO; end
    return x;
  endfunction

  task automatic run_model();
    longint v [6];
    longint acc, d;
    exp_sat = 1'b0;
    exp_clamped = '0;
    for (int i = 0; i < 6; i++) begin
      acc = 0;
      for (int k = 0; k < 6; k++)
        acc += (longint'($signed(inverse[i][k])) * longint'($signed(error[k]))) >>> FRAC;
      v[i] = sat_w(acc);
    end
    for (int i = 0; i < 6; i++) begin
      acc = 0;
      for (int k = 0; k < 6; k++)
        acc += (longint'($signed(jacobian_matrix[k][i])) * v[k]) >>> FRAC;
      d = sat_w(acc);
      if (d > ONE) begin d = ONE; exp_clamped[i] = 1'b1; end
      else if (d < -ONE) begin d = -ONE; exp_clamped[i] = 1'b1; end
      exp_d[i] = d;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      for (int i = 0; i < 6; i++)
        chk($sformatf("dtheta[%0d]", i), longint'($signed(dtheta[i])), exp_d[i]);
      chk("sat", longint'(sat), longint'(exp_sat));
      chk("clamped", longint'(clamped), longint'(exp_clamped));
      chk("busy_in_done", longint'(busy), 1);
    end
  end

  task automatic set_j_diag(input longint a0, a1, a2, a3, a4, a5);
    longint a [6];
    a = '{a0, a1, a2, a3, a4, a5};
    jacobian_matrix = '0;
    for (int i = 0; i < 6; i++) jacobian_matrix[i][i] = W'(a[i]);
  endtask

  task automatic set_m_diag(input longint val);
    inverse = '0;
    for (int i = 0; i < 6; i++) inverse[i][i] = W'(val);
  endtask

  task automatic set_e(input longint a0, a1, a2, a3, a4, a5);
    longint a [6];
    a = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < 6; i++) error[i] = W'(a[i]);
  endtask

  task automatic pin(input string name, input longint l0, l1, l2, l3, l4, l5);
    longint l [6];
    l = '{l0, l1, l2, l3, l4, l5};
    for (int i = 0; i < 6; i++) chk($sformatf("%s_d%0d", name, i), exp_d[i], l[i]);
  endtask

  // Accept edge first, then step edges; n counts edges after the accept edge.
  task automatic go(input int en_off_at, input int en_off_len, input int p1, input int p2,
                    input int rst_at, input int scr_at, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && n < 400) begin
      en    = !(n >= en_off_at && n < en_off_at + en_off_len);
      start = (n == p1) || (n == p2);
      rst   = (n == rst_at);
      if (n == scr_at) begin
        error = ~error;
        inverse = ~inverse;
        jacobian_matrix = ~jacobian_matrix;
      end
      @(posedge clk); #1;
      n++;
      if (rst) begin
        rst = 1'b0;
        break;
      end
      seen = done;
    end
    en = 1'b1;
    start = 1'b0;
  endtask

  task automatic job(input string name, input int exp_n, input int en_off_at, input int en_off_len,
                     input int p1, input int p2, input int scr_at);
    int  n;
    bit  seen;
    go(en_off_at, en_off_len, p1, p2, -1, scr_at, n, seen);
    jobs++;
    chk({name, "_done_seen"}, longint'(seen), 1);
    chk({name, "_latency"}, n, exp_n);
    @(posedge clk); #1;
    chk({name, "_idle_after"}, longint'(busy), 0);
    chk({name, "_done_count"}, n_done, jobs);
  endtask

  initial begin
    int  n;
    bit  seen;
    int  r;
    rst = 1'b1; en = 1'b1; start = 1'b0;
    error = '0; jacobian_matrix = '0; inverse = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_dtheta", longint'(dtheta), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_clamped", longint'(clamped), 0);

    // 1: identity pass-through
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE); set_m_diag(ONE);
    set_e(16384, -32768, 65536, 0, -65536, 49152);
    run_model(); pin("c1", 16384, -32768, 65536, 0, -65536, 49152);
    job("c1", LAT, -1, 0, -1, -1, -1);

    // 2: raw 2.0 clamped to 1.0
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE); set_m_diag(4 * ONE);
    set_e(32768, 32768, 32768, 32768, 32768, 32768);
    run_model(); pin("c2", ONE, ONE, ONE, ONE, ONE, ONE);
    chk("c2_model_clamped", longint'(exp_clamped), 63);
    job("c2", LAT, -1, 0, -1, -1, -1);

    // 3: v saturates, then clamps
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE);
    for (int i = 0; i < 6; i++) for (int k = 0; k < 6; k++) inverse[i][k] = W'(1000 * ONE);
    set_e(ONE, ONE, ONE, ONE, ONE, ONE);
    run_model(); pin("c3", ONE, ONE, ONE, ONE, ONE, ONE);
    chk("c3_model_sat", longint'(exp_sat), 1);
    job("c3", LAT, -1, 0, -1, -1, -1);

    // 4: diagonal J, truncation of half-LSB products
    set_j_diag(32768, 65536, 98304, 131072, 163840, 196608); set_m_diag(ONE);
    set_e(6553, -6553, 6553, -6553, 6553, -6553);
    run_model(); pin("c4", 3276, -6553, 9829, -13106, 16382, -19659);
    job("c4", LAT, -1, 0, -1, -1, -1);
    // 4b: start pulses mid-job, inputs scrambled after accept, start in the DONE cycle
    go(-1, 0, 10, 40, -1, 5, n, seen);
    jobs++;
    chk("c4b_done_seen", longint'(seen), 1);
    chk("c4b_latency", n, LAT);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("c4b_start_in_done_ignored", longint'(busy), 0);
    repeat (5) @(posedge clk);
    #1 chk("c4b_done_count", n_done, jobs);

    // 5: enable dropped for 20 cycles
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE); set_m_diag(ONE);
    set_e(16384, -32768, 65536, 0, -65536, 49152);
    run_model();
    job("c5", LAT + 20, 30, 20, -1, -1, -1);

    // 6: reset mid-job, then restart case 1
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE); set_m_diag(4 * ONE);
    set_e(32768, 32768, 32768, 32768, 32768, 32768);
    run_model();
    go(-1, 0, -1, -1, 50, -1, n, seen);
    chk("c6_rst_busy", longint'(busy), 0);
    chk("c6_rst_dtheta", longint'(dtheta), 0);
    chk("c6_rst_clamped", longint'(clamped), 0);
    chk("c6_rst_sat", longint'(sat), 0);
    chk("c6_rst_done", longint'(done), 0);
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE); set_m_diag(ONE);
    set_e(16384, -32768, 65536, 0, -65536, 49152);
    run_model();
    job("c6r", LAT, -1, 0, -1, -1, -1);

    // 7: negative half-LSB rounds toward -inf
    set_j_diag(ONE, ONE, ONE, ONE, ONE, ONE); set_m_diag(32768);
    set_e(-1, -1, -1, -1, -1, -1);
    run_model(); pin("c7", -1, -1, -1, -1, -1, -1);
    job("c7", LAT, -1, 0, -1, -1, -1);

    // 8: full matrices exercise cross terms and the transpose
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 6; k++) begin
        r = int'($urandom_range(32768)) - 16384;
        inverse[i][k] = W'(r);
        r = int'($urandom_range(32768)) - 16384;
        jacobian_matrix[i][k] = W'(r);
      end
      r = int'($urandom_range(65536)) - 32768;
      error[i] = W'(r);
    end
    run_model();
    job("c8", LAT, -1, 0, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
